// File: rtl/kick_sequencer.sv
// Kick sequencer: accepts ARM/CANCEL command bytes, debounces the IR ball sensor,
// and fires a one-cycle kickstart with a held kicktime code, followed by a cooldown.
module kick_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned COOLDOWN_CYCLES = 25000000,
  parameter int unsigned ARM_TIMEOUT     = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ir_raw,
  output logic       ir,
  output logic [6:0] kicktime,
  output logic       kickstart,
  output logic       armed,
  output logic       kick_done,
  output logic       cmd_err
);

  typedef enum logic [1:0] {IDLE, ARMED, FIRE, COOLDOWN} state_t;

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] COOL_LAST = 26'(COOLDOWN_CYCLES - 1);
  localparam logic [25:0] ARM_LAST  = 26'(ARM_TIMEOUT - 1);

  // IR synchroniser and debounce
  logic        ir_meta;
  logic        ir_sync;
  logic [15:0] deb_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_meta <= 1'b0;
      ir_sync <= 1'b0;
      deb_cnt <= '0;
      ir      <= 1'b0;
    end else begin
      ir_meta <= ir_raw;
      ir_sync <= ir_meta;
      if (ir_sync == ir) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        ir      <= ir_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

  // Command decode
  logic       accept;
  logic [1:0] opcode;
  logic [3:0] strength;
  logic [6:0] arm_code;
  logic       code_ok;
  logic       is_arm;
  logic       is_cancel;
  logic       is_illegal;
  logic       unused_cmd_bits;

  assign accept          = cmd_valid & cmd_ready;
  assign opcode          = cmd_data[7:6];
  assign strength        = cmd_data[3:0];
  assign unused_cmd_bits = ^cmd_data[5:4];

  always_comb begin
    code_ok  = 1'b1;
    arm_code = '0;
    case (strength)
      4'd1:    arm_code = 7'b0000001;
      4'd2:    arm_code = 7'b0000011;
      4'd3:    arm_code = 7'b0000111;
      4'd4:    arm_code = 7'b0011111;
      4'd5:    arm_code = 7'b1000000;
      4'd6:    arm_code = 7'b1100000;
      4'd7:    arm_code = 7'b1110000;
      4'd8:    arm_code = 7'b1111000;
      4'd9:    arm_code = 7'b1111100;
      4'd10:   arm_code = 7'b1111110;
      4'd11:   arm_code = 7'b1111111;
      default: code_ok  = 1'b0;
    endcase
  end

  assign is_arm     = accept && (opcode == 2'b01) && code_ok;
  assign is_cancel  = accept && (opcode == 2'b10);
  assign is_illegal = accept && !is_arm && !is_cancel;

  // Sequencer FSM; one timer serves both the arm timeout and the cooldown
  state_t      state, state_n;
  logic [25:0] timer, timer_n;
  logic [6:0]  code_n;
  logic        done_n;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    timer_n = timer + 26'd1;
    code_n  = kicktime;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        code_n  = '0;
        if (is_arm) begin
          state_n = ARMED;
          code_n  = arm_code;
        end
      end
      ARMED: begin
        if (is_cancel) begin
          state_n = IDLE;
          code_n  = '0;
        end else if (ir) begin
          state_n = FIRE;
          if (is_arm) code_n = arm_code;
        end else if (is_arm) begin
          code_n  = arm_code;
          timer_n = '0;
        end else if (timer == ARM_LAST) begin
          state_n = IDLE;
          code_n  = '0;
        end
      end
      FIRE: begin
        state_n = COOLDOWN;
        timer_n = '0;
      end
      COOLDOWN: begin
        if (timer == COOL_LAST) begin
          state_n = IDLE;
          code_n  = '0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered images of the next state so they change with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      kicktime  <= '0;
      kickstart <= 1'b0;
      armed     <= 1'b0;
      cmd_ready <= 1'b0;
      kick_done <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      kicktime  <= code_n;
      kickstart <= (state_n == FIRE);
      armed     <= (state_n == ARMED);
      cmd_ready <= (state_n == IDLE) || (state_n == ARMED);
      kick_done <= done_n;
      cmd_err   <= is_illegal;
    end
  end

endmodule

// File: tb/tb_kick_sequencer.sv
// Testbench for kick_sequencer: directed stimulus, a deadline-based reference model
// compared on every falling edge, and hand-computed literal expectations.
module tb_kick_sequencer;

  localparam int D = 4;
  localparam int C = 8;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       ir_raw = 1'b0;
  logic       cmd_ready, ir, kickstart, armed, kick_done, cmd_err;
  logic [6:0] kicktime;

  kick_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .COOLDOWN_CYCLES(C),
    .ARM_TIMEOUT    (T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .ir_raw   (ir_raw),
    .ir       (ir),
    .kicktime (kicktime),
    .kickstart(kickstart),
    .armed    (armed),
    .kick_done(kick_done),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases with absolute-cycle deadlines, IR as a run-length rule
  typedef enum {M_IDLE, M_ARMED, M_KICK, M_COOL} mphase_t;
  mphase_t    ph = M_IDLE;
  int         cyc = 0;
  int         deadline = 0;
  int         cool_end = 0;
  int         run = 0;
  bit         raw_q[$];
  bit         m_ready = 0, m_ir = 0, m_kick = 0, m_armed = 0, m_done = 0, m_err = 0;
  logic [6:0] m_code = '0;

  function automatic logic [6:0] code_of(input logic [3:0] s);
    if (s <= 4'd3) return 7'((32'd1 << s) - 32'd1);
    if (s == 4'd4) return 7'b0011111;
    return 7'(7'h7F << (4'd11 - s));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = M_IDLE; run = 0;
      m_ready = 0; m_ir = 0; m_kick = 0; m_armed = 0; m_done = 0; m_err = 0; m_code = '0;
      raw_q.delete(); raw_q.push_back(1'b0); raw_q.push_back(1'b0);
    end else begin
      bit sync_now, acc, larm, canc;
      logic [1:0] op;
      logic [3:0] s;
      sync_now = raw_q.pop_front();
      raw_q.push_back(ir_raw);
      op   = cmd_data[7:6];
      s    = cmd_data[3:0];
      acc  = cmd_valid && m_ready;
      larm = acc && op == 2'b01 && s >= 4'd1 && s <= 4'd11;
      canc = acc && op == 2'b10;
      m_err = acc && !larm && !canc;
      m_done = 0;
      m_kick = 0;
      case (ph)
        M_IDLE: if (larm) begin ph = M_ARMED; m_code = code_of(s); deadline = cyc + T; end
        M_ARMED:
          if (canc) begin ph = M_IDLE; m_code = '0; end
          else if (m_ir) begin ph = M_KICK; m_kick = 1; if (larm) m_code = code_of(s); end
          else if (larm) begin m_code = code_of(s); deadline = cyc + T; end
          else if (cyc == deadline) begin ph = M_IDLE; m_code = '0; end
        M_KICK: begin ph = M_COOL; cool_end = cyc + C; end
        M_COOL: if (cyc == cool_end) begin ph = M_IDLE; m_code = '0; m_done = 1; end
        default: ph = M_IDLE;
      endcase
      m_armed = (ph == M_ARMED);
      m_ready = (ph == M_IDLE) || (ph == M_ARMED);
      if (sync_now != m_ir) begin
        run++;
        if (run == D) begin m_ir = sync_now; run = 0; end
      end else begin
        run = 0;
      end
    end
    cyc++;
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_cmd_ready", cmd_ready, m_ready);
      check("model_ir",        ir,        m_ir);
      check("model_kicktime",  kicktime,  m_code);
      check("model_kickstart", kickstart, m_kick);
      check("model_armed",     armed,     m_armed);
      check("model_kick_done", kick_done, m_done);
      check("model_cmd_err",   cmd_err,   m_err);
    end
  end

  // Present one command from a falling edge; return on the falling edge after acceptance.
  task automatic send(input logic [7:0] b);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic fire_check(input logic [7:0] b, input logic [6:0] code);
    send(b);
    check("armed_after_arm", armed, 1);
    check("code_after_arm", kicktime, code);
    ir_raw = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("ir_latency", ir, i >= 6);
      check("kickstart_time", kickstart, i == 7);
      if (i == 7) check("kicktime_at_fire", kicktime, code);
      check("kick_done_time", kick_done, i == 16);
    end
    check("kicktime_after_done", kicktime, 0);
    ir_raw = 1'b0;
    repeat (8) @(negedge clk);
    check("ir_released", ir, 0);
  endtask

  logic [6:0] exp_code [1:11] = '{7'b0000001, 7'b0000011, 7'b0000111, 7'b0011111,
                                   7'b1000000, 7'b1100000, 7'b1110000, 7'b1111000,
                                   7'b1111100, 7'b1111110, 7'b1111111};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    chk_en = 1;
    #1;
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_kickstart", kickstart, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);

    // Basic fire at strength 5
    fire_check(8'h45, 7'b1000000);

    // Short IR glitch while armed at strength 11, then arm timeout
    send(8'h4B);
    check("glitch_armed", armed, 1);
    check("glitch_code", kicktime, 7'h7F);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("glitch_ir", ir, 0);
      check("glitch_kick", kickstart, 0);
      check("timeout_armed", armed, i < 20);
      if (i == 2) ir_raw = 1'b1;
      if (i == 5) ir_raw = 1'b0;
    end
    check("timeout_code", kicktime, 0);

    // Illegal commands in IDLE, and CANCEL as a no-op
    send(8'h40); check("err_strength0", cmd_err, 1);  check("err0_armed", armed, 0);
    send(8'h4C); check("err_strength12", cmd_err, 1); check("err12_armed", armed, 0);
    send(8'hC3); check("err_opcode3", cmd_err, 1);    check("err3_armed", armed, 0);
    @(negedge clk);
    check("err_pulse_end", cmd_err, 0);
    send(8'h80);
    check("cancel_idle_err", cmd_err, 0);
    check("cancel_idle_armed", armed, 0);

    // Every legal strength maps to its code; cancel clears it
    for (int s = 1; s <= 11; s++) begin
      send(8'h40 | 8'(s));
      check("strength_code", kicktime, exp_code[s]);
      send(8'h80);
      check("cancel_clears", kicktime, 0);
    end

    // Ball present: CANCEL on the fire edge wins
    ir_raw = 1'b1;
    repeat (8) @(negedge clk);
    check("ir_present", ir, 1);
    send(8'h42);
    check("arm2_armed", armed, 1);
    check("arm2_code", kicktime, 7'b0000011);
    send(8'h80);
    check("cancel_fire_armed", armed, 0);
    check("cancel_fire_code", kicktime, 0);
    check("cancel_fire_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cancel_no_kick", kickstart, 0);
    end

    // ARM on the fire edge replaces the code; commands stall through cooldown
    send(8'h4B);
    check("rearm_code", kicktime, 7'h7F);
    send(8'h42);
    check("fire_kick", kickstart, 1);
    check("fire_code", kicktime, 7'b0000011);
    check("fire_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_data  = 8'h45;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      check("cool_ready", cmd_ready, j == 9);
      check("cool_done", kick_done, j == 9);
      check("cool_code", kicktime, (j < 9) ? 7'b0000011 : 7'b0);
      check("cool_armed", armed, 0);
    end
    @(negedge clk);
    check("stalled_arm_taken", armed, 1);
    check("stalled_arm_code", kicktime, 7'b1000000);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("second_fire", kickstart, 1);

    // Reset mid-cooldown and mid-debounce
    ir_raw = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_ir", ir, 0);
    check("rst_kicktime", kicktime, 0);
    check("rst_kickstart", kickstart, 0);
    check("rst_armed", armed, 0);
    check("rst_kick_done", kick_done, 0);
    check("rst_cmd_err", cmd_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    fire_check(8'h49, 7'b1111100);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
